// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel widths, frame defaults, RGB typedefs and channel expansion helper
package pixel_pkg;

  localparam int DEF_IN_BITS  = 4;
  localparam int DEF_OUT_BITS = 8;
  localparam int DEF_H_RES    = 640;
  localparam int DEF_V_RES    = 480;

  typedef struct packed {
    logic [DEF_IN_BITS-1:0] r;
    logic [DEF_IN_BITS-1:0] g;
    logic [DEF_IN_BITS-1:0] b;
  } rgb_in_t;

  typedef struct packed {
    logic [DEF_OUT_BITS-1:0] r;
    logic [DEF_OUT_BITS-1:0] g;
    logic [DEF_OUT_BITS-1:0] b;
  } rgb_out_t;

  // c arrives zero-extended; the right shift yields c[in_bits-1 -: out_bits-in_bits]
  // because in_bits is at least half of out_bits. Widths up to 16 bits.
  function automatic logic [15:0] expand_channel(input logic [15:0] c, input logic mode,
                                                 input int in_bits, input int out_bits);
    logic [15:0] r;
    r = c << (out_bits - in_bits);
    if (mode) r = r | (c >> (2 * in_bits - out_bits));
    return r;
  endfunction

endpackage

// File: rtl/dither_expander_if.sv
// rtl/dither_expander_if.sv - quantized pixel in / restored pixel out stream bundle
import pixel_pkg::*;

interface dither_expander_if #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
);
  logic [3*IN_BITS-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [3*OUT_BITS-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eol;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry valid/ready buffer with registered in_ready
module skid_buffer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         main_valid;
  logic         skid_valid;
  logic         in_xfer;
  logic         out_xfer;

  assign in_ready  = !skid_valid;
  assign out_data  = main_data;
  assign out_valid = main_valid;
  assign in_xfer   = in_valid && !skid_valid;
  assign out_xfer  = main_valid && out_ready;

  // The skid entry only fills while main is stalled, so in_xfer never
  // coincides with a skid-to-main refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data  <= '0;
      skid_data  <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_xfer && skid_valid) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end else if (in_xfer && (!main_valid || out_xfer)) begin
      main_data  <= in_data;
      main_valid <= 1'b1;
    end else if (in_xfer) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/dither_expander.sv
// rtl/dither_expander.sv - RGB bit-depth expander with skid buffer; POSITION_TRACK_EN adds x/y sof/eol tracking
import pixel_pkg::*;

module dither_expander #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SW,
  dither_expander_if.slave  bus
);
  logic [3*OUT_BITS-1:0] conv;

  for (genvar k = 0; k < 3; k++) begin : g_ch
    assign conv[k*OUT_BITS +: OUT_BITS] =
      OUT_BITS'(expand_channel(16'(bus.in_data[k*IN_BITS +: IN_BITS]), SW, IN_BITS, OUT_BITS));
  end

  skid_buffer #(.W(3*OUT_BITS)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (conv),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .out_data (bus.out_data),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );

  // Frames narrower than two pixels or shorter than two lines are not supported.
  if (H_RES < 2 || V_RES < 2) begin : g_bad_frame
  end

`ifdef POSITION_TRACK_EN
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (x == XW'(H_RES - 1)) begin
        x <= '0;
        y <= (y == YW'(V_RES - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign bus.out_sof = bus.out_valid && (x == '0) && (y == '0);
  assign bus.out_eol = bus.out_valid && (x == XW'(H_RES - 1));
`else
  assign bus.out_sof = 1'b0;
  assign bus.out_eol = 1'b0;
`endif
endmodule
